// File: rtl/npu_stream_pkg.sv
// Shared definitions for the NPU host-interface streaming engines.
package npu_stream_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

endpackage

// File: rtl/output_stream_ctrl_if.sv
// Output buffer read port plus host-side valid/ready stream.
interface output_stream_ctrl_if #(
  parameter int DATA_W = npu_stream_pkg::DATA_W,
  parameter int ADDR_W = npu_stream_pkg::ADDR_W
);

  logic              obuf_rd_en;
  logic [ADDR_W-1:0] obuf_rd_addr;
  logic [DATA_W-1:0] obuf_rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output obuf_rd_en, obuf_rd_addr,
    input  obuf_rd_data,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  obuf_rd_en, obuf_rd_addr,
    output obuf_rd_data,
    input  m_data, m_valid, m_last,
    output m_ready
  );

endinterface

// File: rtl/output_stream_ctrl_stream_fifo.sv
// Synchronous prefetch FIFO with a first-word-fall-through head; the head reads
// as zero while empty so the stream data bus is quiet between words.
module stream_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_s;
  logic              pop_s;

  // Push/pop qualification; a push into a full FIFO is accepted when a pop frees the slot.
  always_comb begin
    pop_s  = rd_en && (count_r != {CNT_W{1'b0}});
    push_s = wr_en && ((count_r != CNT_W'(FIFO_DEPTH)) || pop_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Head and status decode.
  always_comb begin
    empty   = (count_r == {CNT_W{1'b0}});
    full    = (count_r == CNT_W'(FIFO_DEPTH));
    count   = count_r;
    rd_data = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
  end

endmodule

// File: rtl/output_stream_ctrl.sv
// Streams a block of output-buffer words to the host: address generation,
// credit-limited read issue into a prefetch FIFO, and last/done signalling.
module output_stream_ctrl
  import npu_stream_pkg::*;
#(
  parameter int DATA_W     = npu_stream_pkg::DATA_W,
  parameter int ADDR_W     = npu_stream_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      num_words,
  output logic                 busy,
  output logic                 done,
  output_stream_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  stream_state_t     state_r;
  stream_state_t     state_s;
  logic [ADDR_W:0]   reads_left_r;
  logic [ADDR_W:0]   words_left_r;
  logic [ADDR_W:0]   count_sat_s;
  logic [ADDR_W-1:0] addr_r;
  logic              inflight_r;
  logic              rd_en_s;
  logic              pop_s;
  logic [CNT_W:0]    occupancy_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [DATA_W-1:0] fifo_head_s;

  // Saturated count, credit check and handshake detect.
  always_comb begin
    count_sat_s = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    occupancy_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r};
    pop_s       = !fifo_empty_s && bus.m_ready;
    if ((state_r == STREAM) && (reads_left_r != {(ADDR_W+1){1'b0}}) &&
        (occupancy_s < (CNT_W+1)'(FIFO_DEPTH))) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (count_sat_s != {(ADDR_W+1){1'b0}}) ? STREAM : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if ((reads_left_r == {(ADDR_W+1){1'b0}}) ||
            (rd_en_s && (reads_left_r == (ADDR_W+1)'(1'b1)))) begin
          state_s = DRAIN;
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (pop_s && (words_left_r == (ADDR_W+1)'(1'b1))) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counters, address generator and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      reads_left_r <= {(ADDR_W+1){1'b0}};
      words_left_r <= {(ADDR_W+1){1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      inflight_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= rd_en_s;
      if ((state_r == IDLE) && start) begin
        addr_r       <= base_addr;
        reads_left_r <= count_sat_s;
        words_left_r <= count_sat_s;
      end else begin
        if (rd_en_s) begin
          addr_r       <= addr_r + ADDR_W'(1'b1);
          reads_left_r <= reads_left_r - (ADDR_W+1)'(1'b1);
        end
        if (pop_s) begin
          words_left_r <= words_left_r - (ADDR_W+1)'(1'b1);
        end
      end
    end
  end

  // Read data lands one cycle after the strobe; a reset drops it via inflight_r.
  stream_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight_r),
    .wr_data (bus.obuf_rd_data),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .count   (fifo_count_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s)
  );

  // Output decode from registered state.
  always_comb begin
    bus.obuf_rd_en   = rd_en_s;
    bus.obuf_rd_addr = addr_r;
    bus.m_data       = fifo_head_s;
    bus.m_valid      = !fifo_empty_s;
    bus.m_last       = !fifo_empty_s && (words_left_r == (ADDR_W+1)'(1'b1));
    busy             = (state_r != IDLE);
    done             = (state_r == DONE);
  end

endmodule

// File: tb/tb_output_stream_ctrl.sv
// Randomised bench for output_stream_ctrl: a queue-based reference model of the
// words and addresses each transfer must produce, checked cycle by cycle.
module tb_output_stream_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;

  output_stream_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  output_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] obuf [1024];

  // Output buffer: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.obuf_rd_en) bus.obuf_rd_data <= obuf[bus.obuf_rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_rd_en"},   bus.obuf_rd_en,   1'b0);
    chk({tag, "_rd_addr"}, bus.obuf_rd_addr, 10'h000);
    chk({tag, "_m_data"},  bus.m_data,       32'h0);
    chk({tag, "_m_valid"}, bus.m_valid,      1'b0);
    chk({tag, "_m_last"},  bus.m_last,       1'b0);
    chk({tag, "_busy"},    busy,             1'b0);
    chk({tag, "_done"},    done,             1'b0);
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run(input int b, input int n, input int rmode, input int restart_k,
                     input int abort_after);
    logic [DW-1:0] exp_q[$];
    int            addr_q[$];
    int            nsat;
    int            issued = 0;
    int            popped = 0;
    int            maxo = 0;
    int            done_k = -1;
    int            pat[4] = '{1, 0, 0, 1};
    bit            fin = 1'b0;
    bit            last_pend = 1'b0;
    bit            exp_done;
    bit            pv = 1'b0;
    bit            pr = 1'b0;
    bit            pl = 1'b0;
    bit            r;
    logic [DW-1:0] pd = '0;

    nsat = (n > 1024) ? 1024 : n;
    for (int i = 0; i < nsat; i++) begin
      addr_q.push_back((b + i) % 1024);
      exp_q.push_back(obuf[(b + i) % 1024]);
    end
    @(negedge clk);
    start     = 1'b1;
    base_addr = b[AW-1:0];
    num_words = n[AW:0];
    for (int k = 0; k < 4000 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == restart_k) begin
        start     = 1'b1;
        base_addr = 10'h155;
        num_words = 11'd5;
      end
      exp_done  = (nsat == 0 && k == 0) || last_pend;
      last_pend = 1'b0;
      chk("done", done, exp_done);
      chk("busy", busy, 1'b1);
      if (done && done_k < 0) done_k = k;
      if (k == 0) chk("first_rd_en", bus.obuf_rd_en, nsat > 0);
      if (rmode == 0 && nsat > 0 && k <= 2) chk("first_valid", bus.m_valid, k == 2);
      if (bus.obuf_rd_en) begin
        chk("rd_pending", addr_q.size() > 0, 1'b1);
        if (addr_q.size() > 0) chk("rd_addr", bus.obuf_rd_addr, addr_q.pop_front());
        issued++;
      end
      if (pv && !pr) begin
        chk("stall_valid", bus.m_valid, 1'b1);
        chk("stall_data",  bus.m_data,  pd);
        chk("stall_last",  bus.m_last,  pl);
      end
      if (bus.m_valid) begin
        chk("word_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("m_data", bus.m_data, exp_q[0]);
          chk("m_last", bus.m_last, exp_q.size() == 1);
        end
      end else begin
        chk("m_last_idle", bus.m_last, 1'b0);
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = pat[k % 4] != 0;
        default: r = $urandom_range(0, 1) != 0;
      endcase
      bus.m_ready = r;
      if (bus.m_valid && r && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        popped++;
        if (exp_q.size() == 0) last_pend = 1'b1;
      end
      if (issued - popped > maxo) maxo = issued - popped;
      pv = bus.m_valid;
      pr = r;
      pd = bus.m_data;
      pl = bus.m_last;
      if (exp_done) fin = 1'b1;
      if (abort_after > 0 && popped == abort_after) break;
    end
    if (abort_after > 0) begin
      chk("abort_reached", popped, abort_after);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      idle_check("mid_reset");
      reset = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("post_reset_valid", bus.m_valid, 1'b0);
        chk("post_reset_rd_en", bus.obuf_rd_en, 1'b0);
      end
    end else begin
      chk("finished", fin, 1'b1);
      chk("all_reads", addr_q.size(), 0);
      chk("max_outstanding", maxo <= DEPTH, 1'b1);
      if (rmode == 0) chk("done_cycle", done_k, (nsat == 0) ? 0 : nsat + 2);
      @(negedge clk);
      chk("done_pulse_end", done, 1'b0);
      chk("busy_end", busy, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) obuf[i] = $urandom;
    reset       = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_words   = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    idle_check("reset");
    reset = 1'b0;

    run(32'h010, 8,  0, -1, 0);
    run(32'h020, 0,  0, -1, 0);
    run(32'h3FE, 4,  0, -1, 0);
    run(32'h040, 16, 1, -1, 0);
    run(32'h080, 10, 0, -1, 3);
    run(32'h090, 2,  0, -1, 0);
    run(32'h100, 8,  0,  2, 0);
    for (int t = 0; t < 6; t++) begin
      run($urandom_range(0, 1023), $urandom_range(1, 20), 2, -1, 0);
    end
    run(32'h3F0, 2047, 0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
